// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter giving requesters A and B single-word access to a DEPTH x WIDTH flip-flop bank.
// Optional lock/burst mode is compiled in when DFF_BANK_LOCK_EN is defined.
module dff_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Cp,
    input  logic             R,
    input  logic             reqA,
    input  logic             weA,
    input  logic [1:0]       addrA,
    input  logic [WIDTH-1:0] dinA,
    input  logic             lockA,
    output logic             gntA,
    output logic             doneA,
    input  logic             reqB,
    input  logic             weB,
    input  logic [1:0]       addrB,
    input  logic [WIDTH-1:0] dinB,
    input  logic             lockB,
    output logic             gntB,
    output logic             doneB,
    output logic [WIDTH-1:0] dout
);
    typedef enum logic [2:0] {IDLE, GNT_A, GNT_B, DONE_A, DONE_B} state_t;

    state_t           r_state;
    logic             r_last;      // 1 = B was served most recently
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_done_a;
    logic             r_done_b;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_sel_b;
    logic             w_in_gnt;
    logic             w_req;
    logic             w_we;
    logic             w_bank_we;
    logic             w_pick_a;
    logic             w_pick_b;
    logic             w_hold_a;
    logic             w_hold_b;
    logic [1:0]       w_addr;
    logic [WIDTH-1:0] w_din;
    logic [WIDTH-1:0] w_rdata;

    // Only the granted requester's controls ever reach the bank.
    assign w_sel_b   = (r_state == GNT_B);
    assign w_in_gnt  = (r_state == GNT_A) || (r_state == GNT_B);
    assign w_req     = w_sel_b ? reqB  : reqA;
    assign w_we      = w_sel_b ? weB   : weA;
    assign w_addr    = w_sel_b ? addrB : addrA;
    assign w_din     = w_sel_b ? dinB  : dinA;
    assign w_bank_we = w_in_gnt && w_req && w_we;
    assign w_pick_a  = reqA && (!reqB || r_last);
    assign w_pick_b  = reqB && !w_pick_a;

    // Out-of-range addresses match no word and therefore read as zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(w_addr) == i) w_rdata = r_mem[i];
        end
    end

    always_ff @(posedge Cp or posedge R) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_bank_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(w_addr) == i) r_mem[i] <= w_din;
            end
        end
    end

`ifdef DFF_BANK_LOCK_EN
    logic [2:0] r_lock_cnt;
    logic       w_to_idle;

    assign w_hold_a  = (r_state == DONE_A) && lockA && reqA && (r_lock_cnt < 3'd4);
    assign w_hold_b  = (r_state == DONE_B) && lockB && reqB && (r_lock_cnt < 3'd4);
    assign w_to_idle = (w_in_gnt && !w_req) ||
                       (r_state == DONE_A && !w_hold_a) ||
                       (r_state == DONE_B && !w_hold_b);

    // Counts accesses completed since the FSM last left IDLE.
    always_ff @(posedge Cp or posedge R) begin
        if (R) begin
            r_lock_cnt <= '0;
        end else if (w_to_idle) begin
            r_lock_cnt <= '0;
        end else if (w_in_gnt && w_req) begin
            r_lock_cnt <= r_lock_cnt + 3'd1;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = lockA | lockB;
    assign w_hold_a      = 1'b0;
    assign w_hold_b      = 1'b0;
`endif

    always_ff @(posedge Cp or posedge R) begin
        if (R) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_gnt_a  <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_gnt_a  <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_a) begin
                        r_state <= GNT_A;
                        r_gnt_a <= 1'b1;
                    end else if (w_pick_b) begin
                        r_state <= GNT_B;
                        r_gnt_b <= 1'b1;
                    end
                end
                GNT_A, GNT_B: begin
                    if (w_req) begin
                        if (!w_we) r_dout <= w_rdata;
                        r_last   <= w_sel_b;
                        r_state  <= w_sel_b ? DONE_B : DONE_A;
                        r_done_a <= !w_sel_b;
                        r_done_b <= w_sel_b;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DONE_A: begin
                    if (w_hold_a) begin
                        r_state <= GNT_A;
                        r_gnt_a <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DONE_B: begin
                    if (w_hold_b) begin
                        r_state <= GNT_B;
                        r_gnt_b <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gntA  = r_gnt_a;
    assign gntB  = r_gnt_b;
    assign doneA = r_done_a;
    assign doneB = r_done_b;
    assign dout  = r_dout;
endmodule
